// File: rtl/instr_encoder.sv
// MIPS32 instruction word assembler with pseudo-instruction expansion (LI, MOVE, B).
// Latency 1 cycle from accept to out_valid; LI with a full 32-bit constant emits two words.
// Backpressure: in_ready drops while a second word is pending or the output is held.
// Optional ENC_ILLEGAL_TRAP_EN: unknown kinds emit a break word and pulse err.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [5:0]  in_opfunct,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        busy,
    output logic        err
);

    localparam logic [3:0] KIND_NOP   = 4'd0;
    localparam logic [3:0] KIND_RTYPE = 4'd1;
    localparam logic [3:0] KIND_ITYPE = 4'd2;
    localparam logic [3:0] KIND_JTYPE = 4'd3;
    localparam logic [3:0] KIND_LI    = 4'd4;
    localparam logic [3:0] KIND_MOVE  = 4'd5;
    localparam logic [3:0] KIND_B     = 4'd6;
    localparam logic [3:0] KIND_ERET  = 4'd7;
    localparam logic [3:0] KIND_MFC0  = 4'd8;
    localparam logic [3:0] KIND_MTC0  = 4'd9;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] FN_ADDU    = 6'h21;

    localparam logic [31:0] WORD_ERET  = 32'h42000018;
    localparam logic [31:0] WORD_BREAK = 32'h0000000D;

    logic        pend_lo;
    logic [31:0] lo_word;

    logic        enc_emit;
    logic        enc_last;
    logic        enc_two;
    logic [31:0] enc_word;
    logic [31:0] enc_lo;

    logic        accept;
    logic        fire;

    assign in_ready = ~pend_lo & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid & out_ready;
    assign busy     = out_valid | pend_lo;

    always_comb begin
        enc_emit = 1'b1;
        enc_last = 1'b1;
        enc_two  = 1'b0;
        enc_word = 32'h0;
        enc_lo   = 32'h0;
        case (in_kind)
            KIND_NOP:   enc_word = 32'h0;
            KIND_RTYPE: enc_word = {OP_SPECIAL, in_rs, in_rt, in_rd, in_shamt, in_opfunct};
            KIND_ITYPE: enc_word = {in_opfunct, in_rs, in_rt, in_imm[15:0]};
            KIND_JTYPE: enc_word = {in_opfunct, in_imm[25:0]};
            KIND_LI: begin
                // Shortest form first: zero-extended, sign-extended, upper-only, then lui+ori.
                if (in_imm[31:16] == 16'h0) begin
                    enc_word = {OP_ORI, 5'd0, in_rt, in_imm[15:0]};
                end else if (&in_imm[31:15]) begin
                    enc_word = {OP_ADDIU, 5'd0, in_rt, in_imm[15:0]};
                end else if (in_imm[15:0] == 16'h0) begin
                    enc_word = {OP_LUI, 5'd0, in_rt, in_imm[31:16]};
                end else begin
                    enc_word = {OP_LUI, 5'd0, in_rt, in_imm[31:16]};
                    enc_last = 1'b0;
                    enc_two  = 1'b1;
                    enc_lo   = {OP_ORI, in_rt, in_rt, in_imm[15:0]};
                end
            end
            KIND_MOVE:  enc_word = {OP_SPECIAL, in_rs, 5'd0, in_rd, 5'd0, FN_ADDU};
            KIND_B:     enc_word = {OP_BEQ, 5'd0, 5'd0, in_imm[15:0]};
            KIND_ERET:  enc_word = WORD_ERET;
            KIND_MFC0:  enc_word = {OP_COP0, 5'h00, in_rt, in_rd, 8'h00, in_imm[2:0]};
            KIND_MTC0:  enc_word = {OP_COP0, 5'h04, in_rt, in_rd, 8'h00, in_imm[2:0]};
            default: begin
`ifdef ENC_ILLEGAL_TRAP_EN
                enc_word = WORD_BREAK;
`else
                enc_emit = 1'b0;
`endif
            end
        endcase
    end

    // pend_lo implies out_valid, so the lo_word swap and a new accept never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_last  <= 1'b0;
            pend_lo   <= 1'b0;
            lo_word   <= 32'h0;
        end else if (pend_lo && out_ready) begin
            out_instr <= lo_word;
            out_last  <= 1'b1;
            pend_lo   <= 1'b0;
        end else if (accept) begin
            out_valid <= enc_emit;
            if (enc_emit) begin
                out_instr <= enc_word;
                out_last  <= enc_last;
            end
            pend_lo <= enc_two;
            if (enc_two) begin
                lo_word <= enc_lo;
            end
        end else if (fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ENC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= accept && (in_kind > KIND_MTC0);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: queue-based reference model plus directed literal checks.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_kind = 4'd0;
    logic [5:0]  in_opfunct = 6'd0;
    logic [4:0]  in_rs = 5'd0;
    logic [4:0]  in_rt = 5'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_shamt = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_last;
    logic        busy;
    logic        err;

    instr_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_opfunct(in_opfunct), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_last(out_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

`ifdef ENC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit accepted = 1'b0;
    bit err_exp = 1'b0;
    int err_pulses = 0;
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    int got_cyc_q[$];
    int acc_cyc_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: list of {last, word} a request must produce, from the ISA field layout.
    task automatic model(input logic [3:0] k, input logic [5:0] of, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [31:0] imm);
        logic [31:0] lo16, hi16;
        lo16 = imm & 32'hFFFF;
        hi16 = imm >> 16;
        case (k)
            0: exp_q.push_back({1'b1, 32'h0});
            1: exp_q.push_back({1'b1, (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(of)});
            2: exp_q.push_back({1'b1, (32'(of) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | lo16});
            3: exp_q.push_back({1'b1, (32'(of) << 26) | (imm % 32'h0400_0000)});
            4: begin
                if (imm <= 32'h0000FFFF)
                    exp_q.push_back({1'b1, 32'h3400_0000 | (32'(rt) << 16) | lo16});
                else if (imm >= 32'hFFFF8000)
                    exp_q.push_back({1'b1, 32'h2400_0000 | (32'(rt) << 16) | lo16});
                else if (lo16 == 0)
                    exp_q.push_back({1'b1, 32'h3C00_0000 | (32'(rt) << 16) | hi16});
                else begin
                    exp_q.push_back({1'b0, 32'h3C00_0000 | (32'(rt) << 16) | hi16});
                    exp_q.push_back({1'b1, 32'h3400_0000 | (32'(rt) << 21) | (32'(rt) << 16) | lo16});
                end
            end
            5: exp_q.push_back({1'b1, (32'(rs) << 21) | (32'(rd) << 11) | 32'h21});
            6: exp_q.push_back({1'b1, 32'h1000_0000 | lo16});
            7: exp_q.push_back({1'b1, 32'h42000018});
            8: exp_q.push_back({1'b1, 32'h4000_0000 | (32'(rt) << 16) | (32'(rd) << 11) | (imm % 8)});
            9: exp_q.push_back({1'b1, 32'h4080_0000 | (32'(rt) << 16) | (32'(rd) << 11) | (imm % 8)});
            default: if (TRAP) exp_q.push_back({1'b1, 32'h0000000D});
        endcase
    endtask

    // Compare process: every negedge, outputs versus the model's outstanding-word queue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(in_ready),
                32'((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)));
            chk("err", 32'(err), 32'(err_exp));
            if (err) err_pulses++;
            accepted = 1'b0;
            if (rst) begin
                exp_q.delete();
                err_exp = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", out_instr, 32'hxxxx_xxxx);
                    end else begin
                        chk("out_instr", out_instr, exp_q[0][31:0]);
                        chk("out_last", 32'(out_last), 32'(exp_q[0][32]));
                        void'(exp_q.pop_front());
                    end
                    got_q.push_back({out_last, out_instr});
                    got_cyc_q.push_back(cyc);
                end
                err_exp = 1'b0;
                if (in_valid && in_ready) begin
                    accepted = 1'b1;
                    acc_cyc_q.push_back(cyc);
                    model(in_kind, in_opfunct, in_rs, in_rt, in_rd, in_shamt, in_imm);
                    if (TRAP && in_kind > 4'd9) err_exp = 1'b1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic [3:0] k, input logic [5:0] of, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
        bit ok;
        in_valid = 1'b1; in_kind = k; in_opfunct = of; in_rs = rs; in_rt = rt;
        in_rd = rd; in_shamt = 5'd0; in_imm = imm;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 32'(in_ready), 32'd1);
        step(1);
    endtask

    task automatic idle_clear();
        in_valid = 1'b0;
        got_q.delete();
        got_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic chk_got(input string nm, input int idx, input logic [31:0] w, input logic l);
        if (got_q.size() <= idx) begin
            chk({nm, "_missing"}, 32'(got_q.size()), 32'(idx + 1));
        end else begin
            chk(nm, got_q[idx][31:0], w);
            chk({nm, "_last"}, 32'(got_q[idx][32]), 32'(l));
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        step(1);
        mon_en = 1'b1;

        // LI two-word expansion at full rate
        idle_clear();
        send(4'd4, 6'd0, 5'd0, 5'd8, 5'd0, 32'h12345678);
        in_valid = 1'b0;
        @(negedge clk);
        chk("li2_in_ready_first", 32'(in_ready), 32'd0);
        step(3);
        chk("li2_count", 32'(got_q.size()), 32'd2);
        chk_got("li2_lui", 0, 32'h3C081234, 1'b0);
        chk_got("li2_ori", 1, 32'h35085678, 1'b1);

        // single-word forms
        idle_clear();
        send(4'd4, 6'd0, 5'd0, 5'd2, 5'd0, 32'h0000ABCD);
        send(4'd4, 6'd0, 5'd0, 5'd2, 5'd0, 32'hFFFF8000);
        send(4'd4, 6'd0, 5'd0, 5'd3, 5'd0, 32'h00010000);
        send(4'd5, 6'd0, 5'd5, 5'd0, 5'd4, 32'h0);
        send(4'd7, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        send(4'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        in_valid = 1'b0;
        step(3);
        chk_got("li_ori", 0, 32'h3402ABCD, 1'b1);
        chk_got("li_addiu", 1, 32'h24028000, 1'b1);
        chk_got("li_lui", 2, 32'h3C030001, 1'b1);
        chk_got("move", 3, 32'h00A02021, 1'b1);
        chk_got("eret", 4, 32'h42000018, 1'b1);
        chk_got("nop", 5, 32'h00000000, 1'b1);

        // back-pressure during the two-word expansion
        idle_clear();
        out_ready = 1'b0;
        send(4'd4, 6'd0, 5'd0, 5'd8, 5'd0, 32'h12345678);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_instr", out_instr, 32'h3C081234);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step(1);
        end
        out_ready = 1'b1;
        step(4);
        chk("bp_count", 32'(got_q.size()), 32'd2);
        chk_got("bp_lui", 0, 32'h3C081234, 1'b0);
        chk_got("bp_ori", 1, 32'h35085678, 1'b1);

        // streaming RTYPE with no bubbles
        idle_clear();
        for (int i = 0; i < 4; i++) send(4'd1, 6'h21, 5'd1, 5'd2, 5'(3 + i), 32'h0);
        in_valid = 1'b0;
        step(3);
        chk("stream_count", 32'(got_q.size()), 32'd4);
        chk_got("stream_first", 0, 32'h00221821, 1'b1);
        if (got_cyc_q.size() == 4 && acc_cyc_q.size() == 4) begin
            chk("stream_latency", 32'(got_cyc_q[0] - acc_cyc_q[0]), 32'd1);
            for (int i = 0; i < 3; i++)
                chk("stream_gap", 32'(got_cyc_q[i + 1] - got_cyc_q[i]), 32'd1);
        end else begin
            chk("stream_records", 32'(got_cyc_q.size()), 32'd4);
        end

        // reset while the lui word is presented
        idle_clear();
        out_ready = 1'b0;
        send(4'd4, 6'd0, 5'd0, 5'd8, 5'd0, 32'h12345678);
        in_valid = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        step(4);
        chk("rst_mid_no_ori", 32'(got_q.size()), 32'd0);

        // unknown kind
        idle_clear();
        err_pulses = 0;
        send(4'd12, 6'd0, 5'd0, 5'd0, 5'd0, 32'h0);
        in_valid = 1'b0;
        step(3);
        chk("unk_err_pulses", 32'(err_pulses), TRAP ? 32'd1 : 32'd0);
        chk("unk_count", 32'(got_q.size()), TRAP ? 32'd1 : 32'd0);
        if (TRAP) chk_got("unk_break", 0, 32'h0000000D, 1'b1);

        // randomized traffic against the model
        idle_clear();
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || accepted) begin
                int sel;
                in_valid = ($urandom_range(0, 3) != 0);
                in_kind = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) in_kind = 4'd4;
                in_opfunct = 6'($urandom);
                in_rs = 5'($urandom); in_rt = 5'($urandom);
                in_rd = 5'($urandom); in_shamt = 5'($urandom);
                sel = $urandom_range(0, 3);
                case (sel)
                    0: in_imm = $urandom & 32'hFFFF;
                    1: in_imm = $urandom | 32'hFFFF8000;
                    2: in_imm = $urandom & 32'hFFFF0000;
                    default: in_imm = $urandom;
                endcase
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step(1);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step(5);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
